clk_meter: RTL and testbench

CLK_METER -- requirements
Module: clk_meter

---
 rtl/clk_meter.sv | 121 ++++++++++++
 tb/tb_clk_meter.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/clk_meter.sv
// Measures period and high time of sig_in in clk cycles, flags lock and overflow.
// Optional CLK_METER_SYNC_EN adds a 2-flop input synchronizer ahead of edge detect.
module clk_meter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             valid,
  output logic             locked,
  output logic             overflow
);

  typedef enum logic [1:0] {IDLE = 2'd0, MEASURE = 2'd1, OVF = 2'd2} state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic             sig_s_q, sig_s_d, sig_p_q, sig_p_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, hcnt_q, hcnt_d;
  logic [CNT_W-1:0] period_q, period_d, high_q, high_d;
  logic             valid_q, valid_d, locked_q, locked_d, ovf_q, ovf_d;
  logic             have_prev_q, have_prev_d;
  logic             sig_src, rise;

`ifdef CLK_METER_SYNC_EN
  logic [1:0] sync_q, sync_d;
  assign sync_d = {sync_q[0], sig_in};
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sync_q <= '0;
    else        sync_q <= sync_d;
  end
  assign sig_src = sync_q[1];
`else
  assign sig_src = sig_in;
`endif

  assign rise = sig_s_q & ~sig_p_q;

  always_comb begin
    state_d     = state_q;
    sig_s_d     = sig_src;
    sig_p_d     = sig_s_q;
    cnt_d       = cnt_q;
    hcnt_d      = hcnt_q;
    period_d    = period_q;
    high_d      = high_q;
    valid_d     = 1'b0;
    locked_d    = locked_q;
    ovf_d       = ovf_q;
    have_prev_d = have_prev_q;
    case (state_q)
      IDLE, OVF: begin
        if (rise) begin
          cnt_d   = CNT_ONE;
          hcnt_d  = CNT_ONE;
          state_d = MEASURE;
        end
      end
      MEASURE: begin
        if (rise) begin
          // previous result is still held on the outputs, so compare against it
          period_d    = cnt_q;
          high_d      = hcnt_q;
          valid_d     = 1'b1;
          locked_d    = have_prev_q && (cnt_q == period_q) && (hcnt_q == high_q);
          have_prev_d = 1'b1;
          cnt_d       = CNT_ONE;
          hcnt_d      = CNT_ONE;
        end else if (cnt_q == CNT_MAX) begin
          state_d     = OVF;
          ovf_d       = 1'b1;
          locked_d    = 1'b0;
          have_prev_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
          if (sig_s_q) hcnt_d = hcnt_q + CNT_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      sig_s_q     <= 1'b0;
      sig_p_q     <= 1'b0;
      cnt_q       <= '0;
      hcnt_q      <= '0;
      period_q    <= '0;
      high_q      <= '0;
      valid_q     <= 1'b0;
      locked_q    <= 1'b0;
      ovf_q       <= 1'b0;
      have_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sig_s_q     <= sig_s_d;
      sig_p_q     <= sig_p_d;
      cnt_q       <= cnt_d;
      hcnt_q      <= hcnt_d;
      period_q    <= period_d;
      high_q      <= high_d;
      valid_q     <= valid_d;
      locked_q    <= locked_d;
      ovf_q       <= ovf_d;
      have_prev_q <= have_prev_d;
    end
  end

  assign period    = period_q;
  assign high_time = high_q;
  assign valid     = valid_q;
  assign locked    = locked_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_clk_meter.sv
// Bench for clk_meter: CNT_W=8 and CNT_W=4 instances share one stimulus stream
// and are checked every cycle against a rise-time/sample-history model.
module tb_clk_meter;

`ifdef CLK_METER_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       sig_in = 1'b0;
  logic [7:0] p8, h8;
  logic [3:0] p4, h4;
  logic       v8, l8, o8, v4, l4, o4;

  int vectors = 0;
  int errs = 0;

  always #5 clk = ~clk;

  clk_meter #(.CNT_W(8)) dut8 (.clk(clk), .reset(reset), .sig_in(sig_in),
    .period(p8), .high_time(h8), .valid(v8), .locked(l8), .overflow(o8));
  clk_meter #(.CNT_W(4)) dut4 (.clk(clk), .reset(reset), .sig_in(sig_in),
    .period(p4), .high_time(h4), .valid(v4), .locked(l4), .overflow(o4));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s @%0t: got %0d, expected %0d", nm, $time, act, exp);
    end
  endtask

  // Model: raw[] holds sig_in as sampled at each edge since reset release.
  bit raw[$];
  int maxv[2] = '{255, 15};
  bit armed[2], ovf_m[2], lock_m[2], prev_ok[2], val_m[2];
  int last[2], per_m[2], hi_m[2];

  // sig_s value after edge j (the synchronizer delays it by LAT edges)
  function automatic bit eff(int j);
    if (j < LAT) return 1'b0;
    return raw[j - LAT];
  endfunction

  task automatic model_reset();
    raw.delete();
    for (int i = 0; i < 2; i++) begin
      armed[i] = 0; ovf_m[i] = 0; lock_m[i] = 0; prev_ok[i] = 0; val_m[i] = 0;
      last[i] = 0; per_m[i] = 0; hi_m[i] = 0;
    end
  endtask

  // Outputs after edge k reflect the rise decision on sig_s of edge k-1.
  task automatic model_step();
    int j, p, h;
    bit rise;
    for (int i = 0; i < 2; i++) val_m[i] = 0;
    if (raw.size() < 2) return;
    j = raw.size() - 2;
    rise = eff(j) && !(j > 0 && eff(j - 1));
    for (int i = 0; i < 2; i++) begin
      if (!armed[i]) begin
        if (rise) begin armed[i] = 1; last[i] = j; end
      end else if (rise) begin
        p = j - last[i];
        h = 0;
        for (int t = last[i]; t < j; t++) h += eff(t);
        lock_m[i] = prev_ok[i] && p == per_m[i] && h == hi_m[i];
        per_m[i] = p; hi_m[i] = h; val_m[i] = 1; prev_ok[i] = 1; last[i] = j;
      end else if (j - last[i] == maxv[i]) begin
        armed[i] = 0; ovf_m[i] = 1; lock_m[i] = 0; prev_ok[i] = 0;
      end
    end
  endtask

  initial begin
    bit smp, rs;
    model_reset();
    forever begin
      @(posedge clk);
      smp = sig_in;
      rs = reset;
      @(negedge clk);
      if (rs) begin raw.push_back(smp); model_step(); end
      if (!reset) model_reset();
      chk("dut8.period",    32'(p8), per_m[0]);
      chk("dut8.high_time", 32'(h8), hi_m[0]);
      chk("dut8.valid",     32'(v8), val_m[0]);
      chk("dut8.locked",    32'(l8), lock_m[0]);
      chk("dut8.overflow",  32'(o8), ovf_m[0]);
      chk("dut4.period",    32'(p4), per_m[1]);
      chk("dut4.high_time", 32'(h4), hi_m[1]);
      chk("dut4.valid",     32'(v4), val_m[1]);
      chk("dut4.locked",    32'(l4), lock_m[1]);
      chk("dut4.overflow",  32'(o4), ovf_m[1]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input bit v, input int n);
    repeat (n) begin sig_in = v; tick(); end
  endtask

  task automatic pattern(input int hi, input int lo, input int reps);
    repeat (reps) begin drive(1'b1, hi); drive(1'b0, lo); end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".p8"}, 32'(p8), 0); chk({tag, ".h8"}, 32'(h8), 0);
    chk({tag, ".v8"}, 32'(v8), 0); chk({tag, ".l8"}, 32'(l8), 0);
    chk({tag, ".o8"}, 32'(o8), 0); chk({tag, ".p4"}, 32'(p4), 0);
    chk({tag, ".v4"}, 32'(v4), 0); chk({tag, ".o4"}, 32'(o4), 0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick(); tick();
    reset = 1'b1;
  endtask

  initial begin
    int hl, ll;
    reset = 1'b0;
    sig_in = 1'b0;
    tick(); tick();
    chk_zero("reset");
    reset = 1'b1;

    // 1 high / 4 low
    pattern(1, 4, 6);
    chk("pin.p8_5", 32'(p8), 5); chk("pin.h8_1", 32'(h8), 1);
    chk("pin.l8_1", 32'(l8), 1); chk("pin.p4_5", 32'(p4), 5);

    // 2h/3l switching to 3h/3l
    pattern(2, 3, 4);
    chk("pin.h8_2", 32'(h8), 2);
    pattern(3, 3, 3);
    chk("pin.p8_6", 32'(p8), 6); chk("pin.h8_3", 32'(h8), 3);
    chk("pin.l8_6", 32'(l8), 1);

    // minimum pattern
    pattern(1, 1, 4);
    chk("pin.p8_2", 32'(p8), 2); chk("pin.h8_1b", 32'(h8), 1);

    // held low after a rise: CNT_W=4 overflows, CNT_W=8 does not
    drive(1'b1, 1);
    drive(1'b0, 15 + LAT);
    chk("pin.o4_pre", 32'(o4), 0);
    drive(1'b0, 1);
    chk("pin.o4_set", 32'(o4), 1); chk("pin.l4_clr", 32'(l4), 0);
    chk("pin.o8_clr", 32'(o8), 0);
    pattern(1, 1, 3);
    chk("pin.o4_sticky", 32'(o4), 1); chk("pin.p4_2", 32'(p4), 2);
    chk("pin.h4_1", 32'(h4), 1);

    // rises exactly 15 apart on CNT_W=4
    do_reset();
    pattern(1, 14, 3);
    chk("pin.p4_15", 32'(p4), 15); chk("pin.o4_15", 32'(o4), 0);

    // async reset mid-period while locked
    pattern(1, 4, 4);
    drive(1'b1, 1);
    drive(1'b0, 2);
    chk("pin.l8_pre", 32'(l8), 1);
    #1 reset = 1'b0;
    #1 chk_zero("async");
    tick(); tick();
    reset = 1'b1;
    pattern(1, 4, 4);

    // high at release counts as a rise; constant high overflows CNT_W=4
    do_reset();
    drive(1'b1, 1);
    drive(1'b0, 1);
    do_reset();
    drive(1'b1, 25);
    drive(1'b0, 3);

    for (int s = 0; s < 60; s++) begin
      hl = $urandom_range(1, 8);
      ll = ($urandom_range(0, 9) == 0) ? $urandom_range(200, 300) : $urandom_range(1, 20);
      drive(1'b1, hl);
      drive(1'b0, ll);
      if ($urandom_range(0, 19) == 0) do_reset();
    end
    tick(); tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
